// File: rtl/lfsr_decrypt_dut.sv
// LFSR message decryptor: loads a 64-byte parity-protected ciphertext,
// recovers seed and tap pattern from the leading-space preamble, then
// writes the stripped, space-padded plaintext back to data memory.
module lfsr_decrypt_dut #(
    parameter int ENC_BASE  = 64,
    parameter int OUT_BASE  = 0,
    parameter int MIN_SPACE = 8
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       req,
    output logic       ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       mem_wen,
    output logic [7:0] mem_wdata,
    output logic [3:0] tap_idx,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DECODE, PAD, DONE} state_t;

    localparam logic [6:0] SPACE = 7'h20;

    function automatic logic [6:0] tap_of(input logic [3:0] k);
        case (k)
            4'd0:    tap_of = 7'h60;
            4'd1:    tap_of = 7'h48;
            4'd2:    tap_of = 7'h78;
            4'd3:    tap_of = 7'h72;
            4'd4:    tap_of = 7'h6A;
            4'd5:    tap_of = 7'h69;
            4'd6:    tap_of = 7'h5C;
            4'd7:    tap_of = 7'h7E;
            4'd8:    tap_of = 7'h7B;
            default: tap_of = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    state_t     state, state_nx;
    logic [7:0] msg [64];
    logic [5:0] idx;
    logic [3:0] cand;
    logic [6:0] wptr, wptr_inc;
    logic [6:0] lfsr, taps, seed_c, s_srch;
    logic       skip, req_q, match;
    logic [7:0] cur;
    logic [6:0] plain;
    logic       par_ok, drop;

    // Candidate-tap check over the preamble and per-byte decode of the current buffer entry.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        taps   = tap_of(cand);
        seed_c = msg[0][6:0] ^ SPACE;
        s_srch = seed_c;
        match  = 1'b1;
        for (int j = 1; j < 16; j++) begin
            if (j < MIN_SPACE) begin
                s_srch = lfsr_step(s_srch, taps);
                if ((msg[6'(j)][6:0] ^ s_srch) != SPACE) match = 1'b0;
            end
        end
        cur      = msg[idx];
        plain    = cur[6:0] ^ lfsr;
        par_ok   = (cur[7] == ^cur[6:0]);
        drop     = skip && par_ok && (plain == SPACE);
        wptr_inc = drop ? wptr : wptr + 7'd1;
    end

    // State register.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic and memory-port drive; req high aborts from any state.
    always_comb begin
        state_nx  = state;
        mem_wen   = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 8'h00;
        if (req) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (req_q) state_nx = LOAD;
                LOAD: begin
                    mem_addr = 8'(ENC_BASE) + {2'b00, idx};
                    if (idx == 6'd63) state_nx = SEARCH;
                end
                SEARCH: begin
                    if (match)              state_nx = DECODE;
                    else if (cand == 4'd8)  state_nx = DONE;
                end
                DECODE: begin
                    if (!drop) begin
                        mem_wen   = 1'b1;
                        mem_addr  = 8'(OUT_BASE) + {1'b0, wptr};
                        mem_wdata = par_ok ? {1'b0, plain} : 8'h80;
                    end
                    if (idx == 6'd63) state_nx = (wptr_inc == 7'd64) ? DONE : PAD;
                end
                PAD: begin
                    mem_wen   = 1'b1;
                    mem_addr  = 8'(OUT_BASE) + {1'b0, wptr};
                    mem_wdata = {1'b0, SPACE};
                    if (wptr == 7'd63) state_nx = DONE;
                end
                default: ;
            endcase
        end
    end

    // Counters, LFSR, search result and done flag.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            req_q   <= 1'b0;
            ack     <= 1'b0;
            idx     <= 6'd0;
            cand    <= 4'd0;
            wptr    <= 7'd0;
            lfsr    <= 7'd0;
            skip    <= 1'b0;
            tap_idx <= 4'd15;
            err     <= 1'b0;
        end else begin
            req_q <= req;
            if (req) begin
                ack <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (req_q) begin
                        ack  <= 1'b0;
                        idx  <= 6'd0;
                        cand <= 4'd0;
                    end
                    LOAD: idx <= idx + 6'd1;
                    SEARCH: begin
                        if (match) begin
                            tap_idx <= cand;
                            err     <= 1'b0;
                            lfsr    <= seed_c;
                            skip    <= 1'b1;
                            wptr    <= 7'd0;
                            idx     <= 6'd0;
                        end else if (cand == 4'd8) begin
                            err     <= 1'b1;
                            tap_idx <= 4'd15;
                            ack     <= 1'b1;
                        end else begin
                            cand <= cand + 4'd1;
                        end
                    end
                    DECODE: begin
                        lfsr <= lfsr_step(lfsr, taps);
                        idx  <= idx + 6'd1;
                        wptr <= wptr_inc;
                        if (!drop) skip <= 1'b0;
                        if (idx == 6'd63 && wptr_inc == 7'd64) ack <= 1'b1;
                    end
                    PAD: begin
                        wptr <= wptr + 7'd1;
                        if (wptr == 7'd63) ack <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Ciphertext buffer fill during LOAD.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; it is always fully rewritten before it is read.
        if (state == LOAD && !req) msg[idx] <= mem_rdata;
    end

endmodule

// File: tb/tb_lfsr_decrypt_dut.sv
// Self-checking bench for lfsr_decrypt_dut: a behavioural encryptor builds
// ciphertexts, a list-level reference decrypts them, and each scenario task
// compares DUT memory writes, flags and latency against it.
module tb_lfsr_decrypt_dut;

    logic       clk = 1'b0;
    logic       init_n, req, ack, mem_wen, err;
    logic [7:0] mem_addr, mem_rdata, mem_wdata;
    logic [3:0] tap_idx;

    logic [7:0] mem [256];
    logic [7:0] plain_img [64];
    logic [7:0] enc_img [64];
    logic [7:0] exp_out [64];
    logic [6:0] taps_tbl [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
    int         exp_k, exp_skip;
    bit         exp_err;
    int         n_pass = 0, n_total = 0;
    int         wr_count = 0, bad_wr = 0;

    lfsr_decrypt_dut dut (
        .clk(clk), .init_n(init_n), .req(req), .ack(ack),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .tap_idx(tap_idx), .err(err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr] = mem_wdata;
            wr_count++;
            if (mem_addr >= 8'd64) bad_wr++;
        end
    end

    function automatic logic [6:0] step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    // Encryptor: each plaintext byte XORed with the running LFSR, even parity in bit 7.
    task automatic encrypt(input logic [6:0] seed, input int k);
        logic [6:0] s, c;
        s = seed;
        for (int i = 0; i < 64; i++) begin
            c = plain_img[i][6:0] ^ s;
            enc_img[i] = {^c, c};
            s = step(s, taps_tbl[k]);
        end
    endtask

    // Reference decryptor working on whole byte lists.
    task automatic model();
        logic [7:0] q[$];
        logic [6:0] seed, s, p;
        bit ok, skipping, par;
        seed = enc_img[0][6:0] ^ 7'h20;
        exp_k = -1;
        for (int k = 0; k < 9 && exp_k < 0; k++) begin
            s = seed; ok = 1;
            for (int j = 1; j < 8; j++) begin
                s = step(s, taps_tbl[k]);
                if ((enc_img[j][6:0] ^ s) != 7'h20) ok = 0;
            end
            if (ok) exp_k = k;
        end
        exp_err = (exp_k < 0);
        exp_skip = 0;
        if (!exp_err) begin
            s = seed; skipping = 1;
            for (int i = 0; i < 64; i++) begin
                p = enc_img[i][6:0] ^ s;
                par = (enc_img[i][7] == ^enc_img[i][6:0]);
                if (skipping && par && p == 7'h20) exp_skip++;
                else begin
                    skipping = 0;
                    q.push_back(par ? {1'b0, p} : 8'h80);
                end
                s = step(s, taps_tbl[exp_k]);
            end
            while (q.size() < 64) q.push_back(8'h20);
            for (int i = 0; i < 64; i++) exp_out[i] = q[i];
        end
    endtask

    task automatic load_mem();
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'hEE;
            mem[64 + i] = enc_img[i];
        end
    endtask

    function automatic int out_diff();
        int n = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_out[i]) n++;
        return n;
    endfunction

    task automatic hello_text(input int spaces);
        logic [39:0] h;
        h = 40'h48656C6C6F;
        for (int i = 0; i < 64; i++) plain_img[i] = 8'($urandom_range(33, 126));
        for (int i = 0; i < spaces; i++) plain_img[i] = 8'h20;
        for (int i = 0; i < 5; i++) plain_img[spaces + i] = h[39 - 8*i -: 8];
    endtask

    // Pulse req, then count edges until ack; lat = -1 on timeout. wr_mark = writes seen by edge 'mark'.
    task automatic run(input int mark, output int lat, output int wr_mark);
        @(posedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        wr_count = 0; bad_wr = 0; lat = -1; wr_mark = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (c == mark) wr_mark = wr_count;
            if (ack) begin lat = c; break; end
        end
    endtask

    task automatic test_reset();
        init_n = 1'b0; req = 1'b0;
        #12;
        if ({ack, mem_wen, mem_addr, mem_wdata, tap_idx, err} !== {1'b0, 1'b0, 8'h00, 8'h00, 4'd15, 1'b0})
            $display("FAIL reset_outputs: got ack=%b wen=%b addr=%h wdata=%h tap=%0d err=%b, want 0 0 00 00 15 0",
                     ack, mem_wen, mem_addr, mem_wdata, tap_idx, err);
        else n_pass++;
        n_total++;
        @(negedge clk); init_n = 1'b1;
    endtask

    task automatic test_hello();
        int lat, wm;
        hello_text(10);
        encrypt(7'h01, 0); load_mem(); model();
        run(0, lat, wm);
        if (lat !== 140) $display("FAIL hello_latency: got %0d want 140", lat); else n_pass++;
        n_total++;
        if (tap_idx !== 4'd0 || err !== 1'b0) $display("FAIL hello_tap: got tap=%0d err=%b want 0 0", tap_idx, err); else n_pass++;
        n_total++;
        if ({mem[0], mem[1], mem[2], mem[3], mem[4]} !== 40'h48656C6C6F)
            $display("FAIL hello_text: got %h want 48656c6c6f", {mem[0], mem[1], mem[2], mem[3], mem[4]});
        else n_pass++;
        n_total++;
        if (out_diff() !== 0) $display("FAIL hello_output: %0d bytes differ, want 0", out_diff()); else n_pass++;
        n_total++;
        if (wr_count !== 64 || bad_wr !== 0) $display("FAIL hello_writes: got %0d (%0d outside OUT) want 64 (0)", wr_count, bad_wr); else n_pass++;
        n_total++;
    endtask

    task automatic test_tap8();
        int lat, wm;
        hello_text(8);
        encrypt(7'h5A, 8); load_mem(); model();
        run(0, lat, wm);
        if (tap_idx !== 4'(exp_k) || err !== 1'b0) $display("FAIL tap8_idx: got tap=%0d err=%b want %0d 0", tap_idx, err, exp_k); else n_pass++;
        n_total++;
        if (lat !== 64 + exp_k + 1 + 64 + exp_skip + 1) $display("FAIL tap8_latency: got %0d want %0d", lat, 130 + exp_k + exp_skip); else n_pass++;
        n_total++;
        if (out_diff() !== 0) $display("FAIL tap8_output: %0d bytes differ, want 0", out_diff()); else n_pass++;
        n_total++;
    endtask

    task automatic test_parity();
        int lat, wm;
        hello_text(10);
        encrypt(7'($urandom_range(1, 127)), 3);
        enc_img[12] = enc_img[12] ^ 8'h80;
        load_mem(); model();
        run(0, lat, wm);
        if (mem[2] !== 8'h80) $display("FAIL parity_marker: got %h want 80", mem[2]); else n_pass++;
        n_total++;
        if (out_diff() !== 0 || tap_idx !== 4'(exp_k)) $display("FAIL parity_output: %0d bytes differ, tap=%0d want 0, %0d", out_diff(), tap_idx, exp_k); else n_pass++;
        n_total++;
    endtask

    task automatic test_all_space();
        int lat, wm, k, n;
        k = $urandom_range(0, 8);
        for (int i = 0; i < 64; i++) plain_img[i] = 8'h20;
        encrypt(7'($urandom_range(1, 127)), k); load_mem(); model();
        run(130 + exp_k, lat, wm);
        n = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== 8'h20) n++;
        if (n !== 0 || wr_count !== 64) $display("FAIL space_output: %0d non-space bytes, %0d writes, want 0, 64", n, wr_count); else n_pass++;
        n_total++;
        if (wm !== 0) $display("FAIL space_decode_writes: got %0d want 0", wm); else n_pass++;
        n_total++;
        if (lat !== 130 + exp_k + 64) $display("FAIL space_latency: got %0d want %0d", lat, 194 + exp_k); else n_pass++;
        n_total++;
    endtask

    task automatic test_no_match();
        int lat, wm;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 64; i++) enc_img[i] = 8'($urandom);
            model();
            if (exp_err) break;
        end
        load_mem();
        run(0, lat, wm);
        if (err !== 1'b1 || tap_idx !== 4'd15) $display("FAIL nomatch_flags: got err=%b tap=%0d want 1 15", err, tap_idx); else n_pass++;
        n_total++;
        if (wr_count !== 0) $display("FAIL nomatch_writes: got %0d want 0", wr_count); else n_pass++;
        n_total++;
        if (lat !== 74) $display("FAIL nomatch_latency: got %0d want 74", lat); else n_pass++;
        n_total++;
    endtask

    task automatic test_abort();
        int snap;
        hello_text(10);
        encrypt(7'($urandom_range(1, 127)), 5); load_mem(); model();
        @(posedge clk); #1 req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        wr_count = 0;
        repeat (86 + exp_k) @(posedge clk);
        #1 req = 1'b1;
        snap = wr_count;
        if (snap !== 20 - exp_skip || tap_idx !== 4'(exp_k))
            $display("FAIL abort_progress: got writes=%0d tap=%0d want %0d %0d", snap, tap_idx, 20 - exp_skip, exp_k);
        else n_pass++;
        n_total++;
        @(posedge clk); #1;
        if (mem_wen !== 1'b0 || ack !== 1'b0) $display("FAIL abort_stop: got wen=%b ack=%b want 0 0", mem_wen, ack); else n_pass++;
        n_total++;
        repeat (10) @(posedge clk);
        #1;
        if (wr_count !== snap || ack !== 1'b0) $display("FAIL abort_quiet: got writes=%0d ack=%b want %0d 0", wr_count, ack, snap); else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_mid_load();
        @(posedge clk); #1 req = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        if (mem_addr !== 8'd93 || tap_idx !== 4'(exp_k)) $display("FAIL load_addr: got addr=%0d tap=%0d want 93 %0d", mem_addr, tap_idx, exp_k); else n_pass++;
        n_total++;
        #2 init_n = 1'b0;
        #1;
        if ({ack, mem_wen, mem_addr, mem_wdata, tap_idx, err} !== {1'b0, 1'b0, 8'h00, 8'h00, 4'd15, 1'b0})
            $display("FAIL midload_reset: got ack=%b wen=%b addr=%h wdata=%h tap=%0d err=%b, want 0 0 00 00 15 0",
                     ack, mem_wen, mem_addr, mem_wdata, tap_idx, err);
        else n_pass++;
        n_total++;
        @(negedge clk); init_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_hello();
        test_tap8();
        test_parity();
        test_all_space();
        test_no_match();
        test_abort();
        test_reset_mid_load();
        test_hello();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
